uart_tx_sched: RTL

Frame sequencer and two-way round-robin arbiter for the UART transmit path. Two requesters share one serial line. The block grants one requester at a time and latches its byte and baud-rate select. It drives the baud generator's rate select and active-low reset, and serialises start, data, optional parity and stop bits on each baud tick. It sits between the client request logic and `baud_gen`, whose `baud_out` pulse feeds `baud_tick`.

---
 rtl/uart_tx_sched.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-way round-robin arbiter plus UART frame sequencer.
// Grants one of two requesters in IDLE, latches its byte and baud select,
// holds the baud generator in reset while idle, then serialises
// start / data (LSB first) / optional parity / stop bits on baud_tick.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit.
//
// Handshake: req is a level request sampled only in IDLE; gnt is a
// one-cycle one-hot pulse on the edge the request is accepted, and the
// captured data/rate are not affected by input changes until the
// frame ends with a one-cycle done pulse.
module uart_tx_sched #(
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   input  logic [1:0]        rate0,
   input  logic [1:0]        rate1,
   output logic [1:0]        gnt,
   output logic              owner,
   input  logic              baud_tick,
   output logic [1:0]        baud_rate,
   output logic              baud_rst_n,
   output logic              tx,
   output logic              busy,
   output logic              done,
   output logic [2:0]        dbg_state
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              stop_cnt_q, stop_cnt_d;
   logic              tx_q, tx_d;
   logic [1:0]        gnt_q, gnt_d;
   logic              done_q, done_d;
   logic              baud_rst_n_q, baud_rst_n_d;
   logic [1:0]        baud_rate_q, baud_rate_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   // Arbitration and helper values used by the next-state logic.
   logic              win;
   logic [DATA_W-1:0] shifted;
   logic              last_stop;

   assign win       = (req == 2'b11) ? ~last_owner_q : req[1];
   assign shifted   = shift_q >> 1;
   assign last_stop = (STOP_BITS == 1) || stop_cnt_q;

   // State and datapath registers; reset restores the idle line.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         stop_cnt_q   <= 1'b0;
         tx_q         <= 1'b1;
         gnt_q        <= 2'b00;
         done_q       <= 1'b0;
         baud_rst_n_q <= 1'b0;
         baud_rate_q  <= 2'b00;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         tx_q         <= tx_d;
         gnt_q        <= gnt_d;
         done_q       <= done_d;
         baud_rst_n_q <= baud_rst_n_d;
         baud_rate_q  <= baud_rate_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
`ifdef UART_TX_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

   // Next-state and registered-output values; pulses default low.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      tx_d         = tx_q;
      gnt_d        = 2'b00;
      done_d       = 1'b0;
      baud_rst_n_d = baud_rst_n_q;
      baud_rate_d  = baud_rate_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
`ifdef UART_TX_PARITY_EN
      parity_d     = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tx_d         = 1'b1;
            baud_rst_n_d = 1'b0;
            // baud_tick is ignored here, including in the grant cycle.
            if (req != 2'b00) begin
               gnt_d        = win ? 2'b10 : 2'b01;
               shift_d      = win ? data1 : data0;
               baud_rate_d  = win ? rate1 : rate0;
               owner_d      = win;
               last_owner_d = win;
               tx_d         = 1'b0;
               baud_rst_n_d = 1'b1;
`ifdef UART_TX_PARITY_EN
               parity_d     = win ? ^data1 : ^data0;
`endif
               state_d      = ST_START;
            end
         end
         ST_START: begin
            if (baud_tick) begin
               tx_d      = shift_q[0];
               bit_cnt_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (baud_tick) begin
               if (bit_cnt_q == CW'(DATA_W - 1)) begin
                  stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = ST_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
`endif
               end else begin
                  shift_d   = shifted;
                  tx_d      = shifted[0];
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_tick) begin
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            tx_d = 1'b1;
            if (baud_tick) begin
               if (last_stop) begin
                  done_d       = 1'b1;
                  baud_rst_n_d = 1'b0;
                  state_d      = ST_IDLE;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: begin
            tx_d         = 1'b1;
            baud_rst_n_d = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase
   end

   assign gnt        = gnt_q;
   assign owner      = owner_q;
   assign baud_rate  = baud_rate_q;
   assign baud_rst_n = baud_rst_n_q;
   assign tx         = tx_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign dbg_state  = state_q;

endmodule
